// File: rtl/ltl_nfa_pkg.sv
// Shared types for the LTL NFA engine: FSM states, STE start types, config kinds.
package ltl_nfa_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      START_NONE = 2'd0,
      START_SOD  = 2'd1,
      START_ALL  = 2'd2,
      START_RSVD = 2'd3
   } start_t;

   typedef enum logic [1:0] {
      CFG_MATCH = 2'd0,
      CFG_ADJ   = 2'd1,
      CFG_ATTR  = 2'd2,
      CFG_RSVD  = 2'd3
   } cfg_kind_t;

endpackage

// File: rtl/ltl_nfa_engine_cell.sv
// One state-transition element: symbol match row, predecessor mask,
// start/report attributes and the active flop.
module nfa_ste_cell
   import ltl_nfa_pkg::*;
#(
   parameter int NUM_STE = 16,
   parameter int SYM_W   = 8,
   parameter int IDX_W   = 3,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_match,
   input  logic               wr_adj,
   input  logic               wr_attr,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [DATA_W-1:0]  cfg_data,
   input  logic [SYM_W-1:0]   sym,
   input  logic               consume,
   input  logic               first,
   input  logic [NUM_STE-1:0] active_vec,
   output logic               active,
   output logic               report_en,
   output logic               active_nxt
);

   localparam int ROW_W = 1 << SYM_W;

   logic [ROW_W-1:0]   row;
   logic [ROW_W-1:0]   wr_bits;
   logic [ROW_W-1:0]   wr_sel;
   logic [NUM_STE-1:0] in_mask;
   start_t             start;

   // Word write: replicate the 32-bit data across the row, select one word.
   for (genvar b = 0; b < ROW_W; b++) begin : g_bit
      assign wr_bits[b] = cfg_data[b % 32];
      assign wr_sel[b]  = (int'(cfg_idx) == b / 32);
   end

   // Configuration tables and active state.
   always_ff @(posedge clk) begin
      if (reset) begin
         row       <= '0;
         in_mask   <= '0;
         start     <= START_NONE;
         report_en <= 1'b0;
         active    <= 1'b0;
      end else begin
         if (wr_match) row <= (row & ~wr_sel) | (wr_bits & wr_sel);
         if (wr_adj)   in_mask <= cfg_data[NUM_STE-1:0];
         if (wr_attr) begin
            start     <= start_t'(cfg_data[1:0]);
            report_en <= cfg_data[2];
         end
         if (consume) active <= active_nxt;
      end
   end

   // Next activation: symbol hit and (active predecessor or start enable).
   // On the first symbol of a stream prior activity is ignored, which makes
   // the active vector effectively zero on entry to RUN.
   always_comb begin
      active_nxt = row[sym] &
                   ((~first & |(active_vec & in_mask)) |
                    (start == START_ALL) |
                    ((start == START_SOD) & first));
   end

endmodule

// File: rtl/ltl_nfa_engine.sv
// Homogeneous NFA engine: an array of STEs stepped once per consumed symbol,
// with per-symbol report vector, saturating report count and first position.
module ltl_nfa_engine
   import ltl_nfa_pkg::*;
#(
   parameter int NUM_STE = 16,
   parameter int SYM_W   = 8,
   parameter int CNT_W   = 16,
   localparam int STE_W  = $clog2(NUM_STE),
   localparam int IDX_W  = (SYM_W > 6) ? SYM_W - 5 : 1,
   localparam int DATA_W = (NUM_STE > 32) ? NUM_STE : 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [1:0]         cfg_kind,
   input  logic [STE_W-1:0]   cfg_ste,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [DATA_W-1:0]  cfg_data,
   input  logic               clear,
   input  logic               sym_valid,
   input  logic [SYM_W-1:0]   sym,
   input  logic               sym_last,
   output logic [NUM_STE-1:0] report_vec,
   output logic               report_valid,
   output logic [CNT_W-1:0]   report_cnt,
   output logic [31:0]        first_pos,
   output logic               done
);

   state_t             state, state_nxt;
   logic               consume, first, cfg_we, any_rep, found;
   logic [31:0]        pos, cur_pos;
   logic [NUM_STE-1:0] active, active_nxt, report_en, rep_nxt;
   cfg_kind_t          kind;

   assign kind    = cfg_kind_t'(cfg_kind);
   assign cfg_we  = cfg_valid & cfg_ready;
   assign rep_nxt = active_nxt & report_en;
   assign any_rep = |rep_nxt;
   assign cur_pos = first ? 32'd0 : pos;

   for (genvar i = 0; i < NUM_STE; i++) begin : g_ste
      nfa_ste_cell #(
         .NUM_STE(NUM_STE), .SYM_W(SYM_W), .IDX_W(IDX_W), .DATA_W(DATA_W)
      ) u_cell (
         .clk        (clk),
         .reset      (reset),
         .wr_match   (cfg_we && kind == CFG_MATCH && int'(cfg_ste) == i),
         .wr_adj     (cfg_we && kind == CFG_ADJ   && int'(cfg_ste) == i),
         .wr_attr    (cfg_we && kind == CFG_ATTR  && int'(cfg_ste) == i),
         .cfg_idx    (cfg_idx),
         .cfg_data   (cfg_data),
         .sym        (sym),
         .consume    (consume),
         .first      (first),
         .active_vec (active),
         .active     (active[i]),
         .report_en  (report_en[i]),
         .active_nxt (active_nxt[i])
      );
   end

   // Next state and FSM-derived strobes. Symbols arriving in DONE are not
   // consumed; the stream source must wait for IDLE.
   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      consume   = 1'b0;
      first     = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            cfg_ready = ~clear & ~reset;
            first     = 1'b1;
            consume   = sym_valid & ~clear;
            if (consume) state_nxt = sym_last ? S_DONE : S_RUN;
         end
         S_RUN: begin
            consume = sym_valid & ~clear;
            if (consume && sym_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = ~reset;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (clear) state_nxt = S_IDLE;
   end

   // State register, report outputs and per-stream statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         report_vec   <= '0;
         report_valid <= 1'b0;
         report_cnt   <= '0;
         first_pos    <= '1;
         pos          <= '0;
         found        <= 1'b0;
      end else begin
         state        <= state_nxt;
         report_valid <= consume;
         if (consume) begin
            report_vec <= rep_nxt;
            pos        <= cur_pos + 32'd1;
            if (first) begin
               report_cnt <= any_rep ? CNT_W'(1) : '0;
               first_pos  <= any_rep ? 32'd0 : '1;
               found      <= any_rep;
            end else if (any_rep) begin
               if (report_cnt != '1) report_cnt <= report_cnt + CNT_W'(1);
               if (!found) begin
                  first_pos <= pos;
                  found     <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/ltl_nfa_engine.md
LTL_NFA_ENGINE -- requirements
Module: ltl_nfa_engine

Interface
REQ-001 SHALL have parameter NUM_STE, 16, number of state-transition elements (2..64).
REQ-002 SHALL have parameter SYM_W, 8, symbol width; each match row holds 2^SYM_W bits.
REQ-003 SHALL have parameter CNT_W, 16, report counter width.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid  in  1  config write request.
REQ-007 SHALL have port cfg_ready  out  1  config write accepted this cycle.
REQ-008 SHALL have port cfg_kind  in  2  0=match word, 1=adjacency, 2=attributes, 3=reserved.
REQ-009 SHALL have port cfg_ste  in  $clog2(NUM_STE)  target STE.
REQ-010 SHALL have port cfg_idx  in  max(1,SYM_W-5)  32-bit word index within a match row.
REQ-011 SHALL have port cfg_data  in  max(32,NUM_STE)  write data.
REQ-012 SHALL have port clear  in  1  abort stream; return to IDLE, keep configuration.
REQ-013 SHALL have port sym_valid  in  1  symbol present.
REQ-014 SHALL have port sym  in  SYM_W  input symbol.
REQ-015 SHALL have port sym_last  in  1  qualifies the final symbol of a stream.
REQ-016 SHALL have port report_vec  out  NUM_STE  active reporting STEs, per symbol.
REQ-017 SHALL have port report_valid  out  1  report_vec qualifier; pulses once per consumed symbol.
REQ-018 SHALL have port report_cnt  out  CNT_W  saturating count of symbols with any report.
REQ-019 SHALL have port first_pos  out  32  position (0-based) of first reporting symbol; all-ones if none.
REQ-020 SHALL have port done  out  1  one-cycle pulse after the sym_last symbol's report.

Function
REQ-021 SHALL implement FSM IDLE -> RUN (on first sym_valid) -> DONE (on sym_valid&sym_last) -> IDLE (next cycle); clear forces IDLE from any state.
REQ-022 SHALL assert cfg_ready only in IDLE with clear low; cfg_kind 3 accepted and ignored.
REQ-023 SHALL on match write set row[cfg_ste] bits [32*cfg_idx +: 32] = cfg_data[31:0].
REQ-024 SHALL on adjacency write set in_mask[cfg_ste] = cfg_data[NUM_STE-1:0]; bit j means edge STE j -> cfg_ste.
REQ-025 SHALL on attribute write set start[cfg_ste] = cfg_data[1:0] (0 none, 1 start-of-data, 2 all-input, 3 = none) and report_en[cfg_ste] = cfg_data[2].
REQ-026 SHALL per consumed symbol compute active'[i] = row[i][sym] & (|(active & in_mask[i]) | start[i]==2 | (start[i]==1 & first symbol)).
REQ-027 SHALL treat the first symbol after IDLE as start-of-data; active SHALL be all-zero on entering RUN.
REQ-028 SHALL hold active, position and counters unchanged on cycles with sym_valid low.
REQ-029 SHALL register report_vec = active' & report_en with report_valid, one cycle after the symbol.
REQ-030 SHALL increment report_cnt when report_vec is nonzero, saturating at 2^CNT_W-1.
REQ-031 SHALL load first_pos with the symbol position only on the first nonzero report_vec of a stream.
REQ-032 SHALL reset active, report_cnt, first_pos and position on entry to RUN, not on DONE; results remain readable in IDLE.
REQ-033 SHALL on clear same cycle as sym_valid drop the symbol; clear dominates cfg_valid.

Reset
REQ-034 SHALL on reset: FSM IDLE, match rows, in_mask, start, report_en, active all zero; report_vec 0, report_valid 0, report_cnt 0, first_pos all-ones, done 0, cfg_ready 0 during reset.

Structure
REQ-035 SHALL put state enum, start-type enum and cfg_kind enum in package ltl_nfa_pkg.
REQ-036 SHALL instantiate NUM_STE copies of sub-module nfa_ste_cell (match row, in_mask, attributes, active flop).

Verification
REQ-037 STE0 start=1 row{0x41}, STE1 row{0x42} report, edge 0->1; stream 0x41,0x42(last) -> report_vec=0x2 at pos 1, report_cnt=1, first_pos=1, done pulse.
REQ-038 STE0 start=2; stream 0x41,0x41,0x42,0x41,0x42 -> reports at pos 2 and 4, report_cnt=2, first_pos=2.
REQ-039 cfg_valid during RUN -> cfg_ready=0, tables unchanged; after done -> write accepted.
REQ-040 CNT_W=4, 20 reporting symbols -> report_cnt=15.
REQ-041 clear after 3 symbols, then stream 0x41 -> treated as start-of-data, counters restarted.
REQ-042 sym_valid gaps of 5 cycles between symbols -> identical reports as gap-free stream.
